dht11_uart_report: RTL



---
 rtl/dht11_pkg.sv | 29 ++
 rtl/dht11_uart_report_tx.sv | 58 +++++
 rtl/dht11_uart_report.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dht11_pkg.sv
// Shared constants, state types and the binary-to-BCD helper for the DHT11 UART logger.
package dht11_pkg;
  localparam int LINE_LEN = 17;

  localparam logic [7:0] ASC_H   = 8'h48;
  localparam logic [7:0] ASC_T   = 8'h54;
  localparam logic [7:0] ASC_EQ  = 8'h3D;
  localparam logic [7:0] ASC_DOT = 8'h2E;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_0   = 8'h30;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN} top_state_t;
  typedef enum logic {TX_IDLE, TX_RUN} tx_state_t;

  // Double-dabble: returns {hundreds, tens, ones}.
  function automatic logic [11:0] byte_to_bcd3(input logic [7:0] b);
    logic [19:0] s;
    s = {12'd0, b};
    for (int i = 0; i < 8; i++) begin
      if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
      if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
      if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
      s = s << 1;
    end
    return s[19:8];
  endfunction
endpackage

// File: rtl/dht11_uart_report_tx.sv
// 8N1 UART transmitter, LSB first; ready also asserts in the last stop-bit cycle
// so characters can be chained with no idle gap.
module uart_tx_8n1
  import dht11_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       tx
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_t   r_state;
  logic [CW-1:0] r_div;
  logic [3:0]  r_bit;
  logic [8:0]  r_shift;
  logic        r_tx;
  logic        w_bit_end;

  assign w_bit_end = (r_div == CW'(DIV - 1));
  assign ready     = (r_state == TX_IDLE) || (w_bit_end && (r_bit == 4'd9));
  assign tx        = r_tx;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_tx    <= 1'b1;
    end else if (start && ready) begin
      r_state <= TX_RUN;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= {1'b1, data};
      r_tx    <= 1'b0;
    end else if (r_state == TX_RUN) begin
      if (w_bit_end) begin
        r_div <= '0;
        if (r_bit == 4'd9) begin
          r_state <= TX_IDLE;
          r_tx    <= 1'b1;
        end else begin
          // Shift register holds data then the stop bit, so bit 8 drives the stop level.
          r_bit   <= r_bit + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_div <= r_div + CW'(1);
      end
    end
  end
endmodule

// File: rtl/dht11_uart_report.sv
// Captures each new DHT11 reading and prints it as "H=hhh.d T=ttt.d\r\n" on a UART.
module dht11_uart_report
  import dht11_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic [31:0] dht11_data,
  input  logic        dht11_data_valid,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  localparam int DIV = CLK_HZ / BAUD;

  logic        r_s1, r_s2, r_s3;
  top_state_t  r_state;
  logic [4:0]  r_idx;
  logic        r_start;
  logic        r_busy;
  logic [7:0]  r_drop;
  logic [11:0] r_hum_bcd, r_tmp_bcd;
  logic [3:0]  r_hum_dec, r_tmp_dec;
  logic        w_rise, w_ready, w_can_take;
  logic [7:0]  w_char;

  function automatic logic [3:0] dec_digit(input logic [7:0] b);
    return (b > 8'd9) ? 4'd9 : b[3:0];
  endfunction

  always_ff @(posedge clk50M) begin
    if (rst) {r_s1, r_s2, r_s3} <= 3'b000;
    else     {r_s1, r_s2, r_s3} <= {dht11_data_valid, r_s1, r_s2};
  end

  assign w_rise = r_s2 & ~r_s3;
  // A rise coinciding with the final stop-bit edge starts the next line directly.
  assign w_can_take = (r_state == ST_IDLE) || ((r_state == ST_DRAIN) && w_ready);

  always_comb begin
    w_char = ASC_SP;
    case (r_idx)
      5'd0:  w_char = ASC_H;
      5'd1:  w_char = ASC_EQ;
      5'd2:  w_char = ASC_0 + {4'd0, r_hum_bcd[11:8]};
      5'd3:  w_char = ASC_0 + {4'd0, r_hum_bcd[7:4]};
      5'd4:  w_char = ASC_0 + {4'd0, r_hum_bcd[3:0]};
      5'd5:  w_char = ASC_DOT;
      5'd6:  w_char = ASC_0 + {4'd0, r_hum_dec};
      5'd7:  w_char = ASC_SP;
      5'd8:  w_char = ASC_T;
      5'd9:  w_char = ASC_EQ;
      5'd10: w_char = ASC_0 + {4'd0, r_tmp_bcd[11:8]};
      5'd11: w_char = ASC_0 + {4'd0, r_tmp_bcd[7:4]};
      5'd12: w_char = ASC_0 + {4'd0, r_tmp_bcd[3:0]};
      5'd13: w_char = ASC_DOT;
      5'd14: w_char = ASC_0 + {4'd0, r_tmp_dec};
      5'd15: w_char = ASC_CR;
      5'd16: w_char = ASC_LF;
      default: w_char = ASC_SP;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_drop    <= '0;
      r_hum_bcd <= '0;
      r_tmp_bcd <= '0;
      r_hum_dec <= '0;
      r_tmp_dec <= '0;
    end else begin
      if (w_rise && !w_can_take && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      if (w_rise && w_can_take) begin
        r_hum_bcd <= byte_to_bcd3(dht11_data[31:24]);
        r_hum_dec <= dec_digit(dht11_data[23:16]);
        r_tmp_bcd <= byte_to_bcd3(dht11_data[15:8]);
        r_tmp_dec <= dec_digit(dht11_data[7:0]);
        r_idx     <= '0;
        r_start   <= 1'b0;
        r_busy    <= 1'b1;
        r_state   <= ST_SEND;
      end else begin
        case (r_state)
          ST_SEND: begin
            r_start <= 1'b1;
            if (r_start && w_ready) begin
              if (r_idx == 5'(LINE_LEN - 1)) begin
                r_start <= 1'b0;
                r_state <= ST_DRAIN;
              end else begin
                r_idx <= r_idx + 5'd1;
              end
            end
          end
          ST_DRAIN: begin
            if (w_ready) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  uart_tx_8n1 #(.DIV(DIV)) u_tx (
    .clk50M (clk50M),
    .rst    (rst),
    .data   (w_char),
    .start  (r_start),
    .ready  (w_ready),
    .tx     (uart_tx)
  );

  assign busy     = r_busy;
  assign drop_cnt = r_drop;
endmodule
